la_wb_initiator: RTL



---
 rtl/la_wb_initiator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/la_wb_initiator.sv
// la_wb_initiator: Wishbone classic initiator driven from logic-analyzer bits.
// Each 0->1 edge of cmd_req runs one single read/write cycle on wbm_*.
// Completion is reported through rsp_valid/rsp_done/rsp_dat.
// Optional macro WBM_TIMEOUT_EN adds an ack timeout that aborts the cycle
// after TIMEOUT_CYCLES bus cycles. It then reports rsp_err and returns ERR_DATA.
module la_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_req,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_done,
  output logic        rsp_err,
  output logic [31:0] rsp_dat,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic {IDLE, BUS} state_e;

  state_e      state_q, state_d;
  logic        req_q;
  logic        start;
  logic        timeout;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_done_q, rsp_done_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

  assign start = cmd_req & ~req_q;

`ifdef WBM_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       rsp_err_q, rsp_err_d;

  // An ack in the final counted cycle wins over the timeout.
  assign timeout = (state_q == BUS) & ~wbm_ack_i & (cnt_q == CNT_LAST);
  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: a single bus cycle per accepted edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = BUS;
      BUS:  if (wbm_ack_i || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch the command, capture the response
  always_comb begin
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_done_d  = rsp_done_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          we_d       = cmd_we;
          adr_d      = cmd_adr;
          dat_d      = cmd_dat;
          sel_d      = cmd_sel;
          rsp_done_d = 1'b0;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d  = 1'b0;
          cnt_d      = '0;
`endif
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          rsp_valid_d = 1'b1;
          rsp_done_d  = 1'b1;
          if (!we_q) rsp_dat_d = wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_done_d  = 1'b1;
          rsp_dat_d   = ERR_DATA;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d   = 1'b1;
`endif
        end else begin
`ifdef WBM_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; req_q tracks cmd_req every cycle so busy-time edges are lost
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_done_q  <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      req_q       <= cmd_req;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_done_q  <= rsp_done_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign busy      = (state_q == BUS);
  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_done  = rsp_done_q;
  assign rsp_dat   = rsp_dat_q;

endmodule
